// File: rtl/tmds_link_sequencer.sv
// Link bring-up sequencer and per-cycle TMDS period scheduler for three serializer lanes.
// A 10-stage delay line gives the DE lookahead needed to place preamble and guard band.
module tmds_link_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int FLUSH_CYCLES = 64,
  parameter int HDMI_MODE    = 1
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_pll_locked,
  input  logic       i_de,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [9:0] i_tmds_ch0,
  input  logic [9:0] i_tmds_ch1,
  input  logic [9:0] i_tmds_ch2,
  output logic [9:0] o_ch0,
  output logic [9:0] o_ch1,
  output logic [9:0] o_ch2,
  output logic       o_serdes_rst,
  output logic       o_link_up,
  output logic       o_blank_err
);

  localparam logic [2:0] WAIT_LOCK = 3'd0;
  localparam logic [2:0] SRST      = 3'd1;
  localparam logic [2:0] FLUSH     = 3'd2;
  localparam logic [2:0] WAIT_VS   = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;
  localparam logic [9:0] GB_02  = 10'b1011001100;
  localparam logic [9:0] GB_1   = 10'b0100110011;

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    case (c)
      2'b00:   ctl_token = TOK_00;
      2'b01:   ctl_token = TOK_01;
      2'b10:   ctl_token = TOK_10;
      default: ctl_token = TOK_11;
    endcase
  endfunction

  // Stage packing: {de, vsync, hsync, ch2, ch1, ch0}
  logic [32:0] dl_reg [10];
  logic [32:0] in_vec;
  logic [32:0] tap;
  logic [10:1] ahead;

  assign in_vec = {i_de, i_vsync, i_hsync, i_tmds_ch2, i_tmds_ch1, i_tmds_ch0};
  assign tap    = dl_reg[9];

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge i_clk) begin
          if (i_srst) dl_reg[gi] <= '0;
          else        dl_reg[gi] <= in_vec;
        end
      end else begin : g_rest
        always_ff @(posedge i_clk) begin
          if (i_srst) dl_reg[gi] <= '0;
          else        dl_reg[gi] <= dl_reg[gi-1];
        end
      end
    end
    // ahead[k] is the DE that follows the tapped cycle by k cycles
    for (gi = 1; gi < 10; gi++) begin : g_ahead
      assign ahead[gi] = dl_reg[9-gi][32];
    end
  endgenerate
  assign ahead[10] = i_de;

  logic       tap_de, tap_vs, tap_hs;
  logic       guard_zone, pre_zone;
  logic [2:0] state_reg, state_next;
  logic [9:0] cnt_reg;
  logic [3:0] blank_cnt_reg;
  logic       de_prev_reg, vs_prev_reg;
  logic [9:0] ch0_reg, ch1_reg, ch2_reg;
  logic [9:0] ch0_next, ch1_next, ch2_next;
  logic       err_reg, err_next;

  assign tap_de     = tap[32];
  assign tap_vs     = tap[31];
  assign tap_hs     = tap[30];
  assign guard_zone = ahead[1] | ahead[2];
  assign pre_zone   = |ahead[10:3];

  always_comb begin
    state_next = state_reg;
    if (!i_pll_locked) begin
      state_next = WAIT_LOCK;
    end else begin
      case (state_reg)
        WAIT_LOCK: state_next = SRST;
        SRST:      if (cnt_reg == 10'(RST_CYCLES - 1)) state_next = FLUSH;
        FLUSH:     if (cnt_reg == 10'(FLUSH_CYCLES - 1)) state_next = WAIT_VS;
        WAIT_VS:   if (tap_vs && !vs_prev_reg) state_next = RUN;
        RUN:       state_next = RUN;
        default:   state_next = WAIT_LOCK;
      endcase
    end
  end

  // Output words follow the next state so they change together with link_up/serdes_rst.
  always_comb begin
    ch0_next = TOK_00;
    ch1_next = TOK_00;
    ch2_next = TOK_00;
    case (state_next)
      FLUSH, WAIT_VS: begin
        ch0_next = ctl_token({tap_vs, tap_hs});
      end
      RUN: begin
        if (tap_de) begin
          ch0_next = tap[9:0];
          ch1_next = tap[19:10];
          ch2_next = tap[29:20];
        end else if (HDMI_MODE != 0 && guard_zone) begin
          ch0_next = GB_02;
          ch1_next = GB_1;
          ch2_next = GB_02;
        end else if (HDMI_MODE != 0 && pre_zone) begin
          ch0_next = ctl_token({tap_vs, tap_hs});
          ch1_next = TOK_01;
        end else begin
          ch0_next = ctl_token({tap_vs, tap_hs});
        end
      end
      default: ;
    endcase
  end

  assign err_next = (state_next == RUN) && tap_de && !de_prev_reg && (blank_cnt_reg < 4'd12);

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_reg     <= WAIT_LOCK;
      cnt_reg       <= '0;
      blank_cnt_reg <= '0;
      de_prev_reg   <= 1'b0;
      vs_prev_reg   <= 1'b0;
      ch0_reg       <= TOK_00;
      ch1_reg       <= TOK_00;
      ch2_reg       <= TOK_00;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg)                   cnt_reg <= '0;
      else if (state_reg == SRST || state_reg == FLUSH) cnt_reg <= cnt_reg + 10'd1;
      if (tap_de)                     blank_cnt_reg <= '0;
      else if (blank_cnt_reg != 4'd15) blank_cnt_reg <= blank_cnt_reg + 4'd1;
      de_prev_reg <= tap_de;
      vs_prev_reg <= tap_vs;
      ch0_reg     <= ch0_next;
      ch1_reg     <= ch1_next;
      ch2_reg     <= ch2_next;
      err_reg     <= err_next;
    end
  end

  assign o_ch0        = ch0_reg;
  assign o_ch1        = ch1_reg;
  assign o_ch2        = ch2_reg;
  assign o_serdes_rst = (state_reg == WAIT_LOCK) || (state_reg == SRST);
  assign o_link_up    = (state_reg == RUN);
  assign o_blank_err  = err_reg;

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Directed bench: an HDMI-mode and a DVI-mode sequencer share one stimulus stream,
// outputs are compared 11 cycles after each input vector against hand-derived tables.
module tb_tmds_link_sequencer;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] G0  = 10'b1011001100;
  localparam logic [9:0] G1  = 10'b0100110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst, locked, de, hs, vs;
  logic [9:0] w0, w1, w2;
  logic [9:0] h_ch0, h_ch1, h_ch2, d_ch0, d_ch1, d_ch2;
  logic       h_rst, h_link, h_err, d_rst, d_link, d_err;

  tmds_link_sequencer #(.RST_CYCLES(16), .FLUSH_CYCLES(64), .HDMI_MODE(1)) dut_h (
    .i_clk(clk), .i_srst(srst), .i_pll_locked(locked), .i_de(de), .i_hsync(hs), .i_vsync(vs),
    .i_tmds_ch0(w0), .i_tmds_ch1(w1), .i_tmds_ch2(w2),
    .o_ch0(h_ch0), .o_ch1(h_ch1), .o_ch2(h_ch2),
    .o_serdes_rst(h_rst), .o_link_up(h_link), .o_blank_err(h_err));

  tmds_link_sequencer #(.RST_CYCLES(16), .FLUSH_CYCLES(64), .HDMI_MODE(0)) dut_d (
    .i_clk(clk), .i_srst(srst), .i_pll_locked(locked), .i_de(de), .i_hsync(hs), .i_vsync(vs),
    .i_tmds_ch0(w0), .i_tmds_ch1(w1), .i_tmds_ch2(w2),
    .o_ch0(d_ch0), .o_ch1(d_ch1), .o_ch2(d_ch2),
    .o_serdes_rst(d_rst), .o_link_up(d_link), .o_blank_err(d_err));

  int errors = 0;
  int checks = 0;

  logic       s_de [64];
  logic       s_hs [64];
  logic       s_vs [64];
  logic [9:0] s_w  [64];
  logic [9:0] e_h0 [64];
  logic [9:0] e_h1 [64];
  logic [9:0] e_h2 [64];
  logic [9:0] e_d0 [64];
  logic [9:0] e_d1 [64];
  logic [9:0] e_d2 [64];
  logic       e_err [64];
  logic       e_link [64];

  // Distinct per-lane words so a lane swap is visible.
  function automatic logic [9:0] lane(input int n, input logic [9:0] w);
    if (n == 0)      lane = w;
    else if (n == 1) lane = ~w;
    else             lane = {w[4:0], w[9:5]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [9:0] obs, input logic [9:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s[%0d]: observed=%h expected=%h", tag, idx, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input int idx, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s[%0d]: observed=%b expected=%b", tag, idx, obs, exp_v);
    end
  endtask

  task automatic drive(input logic d, input logic h, input logic v, input logic [9:0] w);
    de = d; hs = h; vs = v;
    w0 = lane(0, w); w1 = lane(1, w); w2 = lane(2, w);
  endtask

  task automatic set_stim(input int a, input int b, input logic d, input logic h, input logic v,
                          input logic [9:0] w);
    for (int i = a; i <= b; i++) begin
      s_de[i] = d; s_hs[i] = h; s_vs[i] = v; s_w[i] = w;
    end
  endtask

  task automatic set_exp(input int a, input int b, input logic [9:0] h0, input logic [9:0] h1,
                         input logic [9:0] h2, input logic [9:0] d0, input logic [9:0] d1,
                         input logic [9:0] d2, input logic err, input logic link);
    for (int i = a; i <= b; i++) begin
      e_h0[i] = h0; e_h1[i] = h1; e_h2[i] = h2;
      e_d0[i] = d0; e_d1[i] = d1; e_d2[i] = d2;
      e_err[i] = err; e_link[i] = link;
    end
  endtask

  task automatic set_video(input int a, input int b, input logic [9:0] w, input logic err);
    set_exp(a, b, lane(0, w), lane(1, w), lane(2, w), lane(0, w), lane(1, w), lane(2, w), err, 1'b1);
  endtask

  // Vector i is applied, one edge later the output shows vector i-10's result
  task automatic run_seg(input int n);
    for (int i = 0; i < n; i++) begin
      drive(s_de[i], s_hs[i], s_vs[i], s_w[i]);
      tick();
      if (i >= 10) begin
        int j;
        j = i - 10;
        chk("h_ch0", j, h_ch0, e_h0[j]);
        chk("h_ch1", j, h_ch1, e_h1[j]);
        chk("h_ch2", j, h_ch2, e_h2[j]);
        chk("d_ch0", j, d_ch0, e_d0[j]);
        chk("d_ch1", j, d_ch1, e_d1[j]);
        chk("d_ch2", j, d_ch2, e_d2[j]);
        chk1("h_err", j, h_err, e_err[j]);
        chk1("d_err", j, d_err, e_err[j]);
        chk1("h_link", j, h_link, e_link[j]);
        chk1("d_link", j, d_link, e_link[j]);
      end
    end
  endtask

  // Called at the sample point just after the edge that enters SRST
  task automatic bringup();
    for (int i = 0; i < 16; i++) begin
      chk1("srst_rst", i, h_rst, 1'b1);
      chk1("srst_rst_d", i, d_rst, 1'b1);
      chk("srst_ch0", i, h_ch0, T00);
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      chk1("flush_rst", i, h_rst, 1'b0);
      chk1("flush_link", i, h_link, 1'b0);
      chk("flush_ch0", i, h_ch0, T00);
      chk("flush_ch1", i, h_ch1, T00);
      tick();
    end
    chk1("waitvs_rst", 0, h_rst, 1'b0);
    chk1("waitvs_link", 0, h_link, 1'b0);
    chk1("waitvs_link_d", 0, d_link, 1'b0);
  endtask

  task automatic seg_vsync();
    set_stim(0, 29, 1'b0, 1'b0, 1'b0, 10'h000);
    set_stim(5, 7, 1'b0, 1'b0, 1'b1, 10'h000);
    set_exp(0, 4, T00, T00, T00, T00, T00, T00, 1'b0, 1'b0);
    set_exp(5, 7, T10, T00, T00, T10, T00, T00, 1'b0, 1'b1);
    set_exp(8, 19, T00, T00, T00, T00, T00, T00, 1'b0, 1'b1);
    run_seg(30);
  endtask

  initial begin
    srst = 1'b1; locked = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 10'h000);
    repeat (3) tick();
    chk("rst_ch0", 0, h_ch0, T00);
    chk("rst_ch1", 0, h_ch1, T00);
    chk("rst_ch2", 0, h_ch2, T00);
    chk1("rst_serdes", 0, h_rst, 1'b1);
    chk1("rst_link", 0, h_link, 1'b0);
    chk1("rst_err", 0, h_err, 1'b0);
    locked = 1'b1;
    tick();
    chk1("rst_over_lock", 0, h_rst, 1'b1);
    srst = 1'b0;
    tick();
    bringup();
    seg_vsync();

    // 20 blank then 8 video: 10 control, 8 preamble, 2 guard, 8 video
    set_stim(0, 41, 1'b0, 1'b0, 1'b0, 10'h000);
    set_stim(20, 27, 1'b1, 1'b0, 1'b0, 10'h2AB);
    set_exp(0, 9, T00, T00, T00, T00, T00, T00, 1'b0, 1'b1);
    set_exp(10, 17, T00, T01, T00, T00, T00, T00, 1'b0, 1'b1);
    set_exp(18, 19, G0, G1, G0, T00, T00, T00, 1'b0, 1'b1);
    set_video(20, 27, 10'h2AB, 1'b0);
    set_exp(28, 31, T00, T00, T00, T00, T00, T00, 1'b0, 1'b1);
    run_seg(42);

    // 5-cycle blanking: 3 preamble + 2 guard, error pulse on first new video word
    set_stim(0, 34, 1'b0, 1'b0, 1'b0, 10'h000);
    set_stim(0, 7, 1'b1, 1'b0, 1'b0, 10'h155);
    set_stim(13, 20, 1'b1, 1'b0, 1'b0, 10'h0F0);
    set_video(0, 7, 10'h155, 1'b0);
    set_exp(8, 10, T00, T01, T00, T00, T00, T00, 1'b0, 1'b1);
    set_exp(11, 12, G0, G1, G0, T00, T00, T00, 1'b0, 1'b1);
    set_video(13, 13, 10'h0F0, 1'b1);
    set_video(14, 20, 10'h0F0, 1'b0);
    set_exp(21, 24, T00, T00, T00, T00, T00, T00, 1'b0, 1'b1);
    run_seg(35);

    // Sync tokens on ch0 during control
    set_stim(0, 35, 1'b0, 1'b0, 1'b0, 10'h000);
    set_stim(0, 11, 1'b0, 1'b1, 1'b0, 10'h000);
    set_stim(12, 23, 1'b0, 1'b1, 1'b1, 10'h000);
    set_exp(0, 11, T01, T00, T00, T01, T00, T00, 1'b0, 1'b1);
    set_exp(12, 23, T11, T00, T00, T11, T00, T00, 1'b0, 1'b1);
    set_exp(24, 25, T00, T00, T00, T00, T00, T00, 1'b0, 1'b1);
    run_seg(36);

    // Lock loss mid-video
    drive(1'b1, 1'b0, 1'b0, 10'h3C3);
    repeat (15) tick();
    chk("vid_ch0", 0, h_ch0, lane(0, 10'h3C3));
    chk("vid_ch1", 0, h_ch1, lane(1, 10'h3C3));
    chk1("vid_link", 0, h_link, 1'b1);
    locked = 1'b0;
    tick();
    chk1("drop_rst", 0, h_rst, 1'b1);
    chk1("drop_link", 0, h_link, 1'b0);
    chk("drop_ch0", 0, h_ch0, T00);
    chk("drop_ch1", 0, h_ch1, T00);
    chk("drop_ch2", 0, h_ch2, T00);
    chk1("drop_rst_d", 0, d_rst, 1'b1);
    chk("drop_ch0_d", 0, d_ch0, T00);
    drive(1'b0, 1'b0, 1'b0, 10'h000);
    repeat (3) tick();
    chk1("unlocked_rst", 0, h_rst, 1'b1);
    chk1("unlocked_link", 0, h_link, 1'b0);
    locked = 1'b1;
    tick();
    bringup();
    seg_vsync();

    // Synchronous reset while running
    drive(1'b1, 1'b1, 1'b0, 10'h1E1);
    repeat (12) tick();
    srst = 1'b1;
    tick();
    chk1("midrst_rst", 0, h_rst, 1'b1);
    chk1("midrst_link", 0, h_link, 1'b0);
    chk("midrst_ch0", 0, h_ch0, T00);
    chk("midrst_ch1", 0, h_ch1, T00);
    chk1("midrst_err", 0, h_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
